mdu: RTL and testbench

Iterative multiply/divide unit for the EX stage, alongside `alu`. Takes the same A/B operands the ALU receives from the register-file read stage and produces the 64-bit result into architectural HI/LO registers. The unit stalls the pipeline through `Busy` while a multi-cycle operation runs. HI/LO are read back by the writeback mux.

---
 rtl/mdu.sv | 202 ++++++++++++++++++++
 tb/tb_mdu.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/mdu.sv
// mdu: iterative multiply/divide unit for the EX stage.
// Multiply is radix-2 shift-add, divide is restoring; both retire one bit per
// clock over WIDTH cycles. mthi/mtlo write HI/LO in a single cycle.
// Define MDU_DIV_EN to compile in the divide datapath. Without it, div/divu
// are treated as no-ops.
module mdu #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [2:0]       MDOp,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
`ifdef MDU_DIV_EN
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
`endif
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  // Multiplicand magnitude for multiply, divisor magnitude for divide.
  logic [WIDTH-1:0]   opd_q, opd_d;
  // Multiply: {partial product, remaining multiplier bits}.
  // Divide:   {partial remainder, remaining dividend / quotient bits}.
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               neg_q_q, neg_q_d;   // negate product / quotient at the end
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
`ifdef MDU_DIV_EN
  logic               is_div_q, is_div_d;
  logic               neg_r_q, neg_r_d;   // remainder takes the dividend's sign
  logic               bzero_q, bzero_d;   // divide by zero forces LO to all ones
`endif

  // Operand sign and magnitude; mult and div (even opcodes) are the signed forms.
  logic             signed_op;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  assign signed_op = ~MDOp[0];
  assign a_neg     = signed_op & A[WIDTH-1];
  assign b_neg     = signed_op & B[WIDTH-1];
  assign a_mag     = a_neg ? -A : A;
  assign b_mag     = b_neg ? -B : B;

  // One shift-add multiply step: add the multiplicand when the low multiplier
  // bit is set, then shift the whole accumulator right by one.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opd_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  logic [2*WIDTH-1:0] step_next;
`ifdef MDU_DIV_EN
  // One restoring divide step: shift in the next dividend bit, trial-subtract
  // the divisor, keep the difference only when it did not go negative.
  logic [WIDTH:0]     rem_sh, diff;
  logic [2*WIDTH-1:0] div_next;
  assign rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
  assign diff     = rem_sh - {1'b0, opd_q};
  assign div_next = diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                : {diff[WIDTH-1:0],   acc_q[WIDTH-2:0], 1'b1};
  assign step_next = is_div_q ? div_next : mul_next;
`else
  assign step_next = mul_next;
`endif

  // Signed results: full 64-bit negate for products, per-half for divide.
  logic [2*WIDTH-1:0] prod_fix;
  assign prod_fix = neg_q_q ? -step_next : step_next;
`ifdef MDU_DIV_EN
  logic [WIDTH-1:0] quo_fix, rem_fix;
  assign quo_fix = bzero_q ? '1 :
                   (neg_q_q ? -step_next[WIDTH-1:0] : step_next[WIDTH-1:0]);
  assign rem_fix = neg_r_q ? -step_next[2*WIDTH-1:WIDTH] : step_next[2*WIDTH-1:WIDTH];
`endif

  // Next-state and datapath control: accept in IDLE, iterate and retire in RUN.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    opd_d    = opd_q;
    acc_d    = acc_q;
    neg_q_d  = neg_q_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
`ifdef MDU_DIV_EN
    is_div_d = is_div_q;
    neg_r_d  = neg_r_q;
    bzero_d  = bzero_q;
`endif
    case (state_q)
      IDLE: begin
        if (Start) begin
          case (MDOp)
            OP_MULT, OP_MULTU: begin
              opd_d    = a_mag;
              acc_d    = {{WIDTH{1'b0}}, b_mag};
              neg_q_d  = a_neg ^ b_neg;
              cnt_d    = '0;
              state_d  = RUN;
`ifdef MDU_DIV_EN
              is_div_d = 1'b0;
              neg_r_d  = 1'b0;
              bzero_d  = 1'b0;
`endif
            end
`ifdef MDU_DIV_EN
            OP_DIV, OP_DIVU: begin
              opd_d    = b_mag;
              acc_d    = {{WIDTH{1'b0}}, a_mag};
              neg_q_d  = a_neg ^ b_neg;
              neg_r_d  = a_neg;
              bzero_d  = (B == '0);
              is_div_d = 1'b1;
              cnt_d    = '0;
              state_d  = RUN;
            end
`endif
            OP_MTHI: hi_d = A;
            OP_MTLO: lo_d = A;
            default: ;
          endcase
        end
      end
      RUN: begin
        acc_d = step_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_STEP) begin
          state_d = IDLE;
          cnt_d   = '0;
`ifdef MDU_DIV_EN
          if (is_div_q) begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end else begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end
`else
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!Reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      opd_q    <= '0;
      acc_q    <= '0;
      neg_q_q  <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
`ifdef MDU_DIV_EN
      is_div_q <= 1'b0;
      neg_r_q  <= 1'b0;
      bzero_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      opd_q    <= opd_d;
      acc_q    <= acc_d;
      neg_q_q  <= neg_q_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
`ifdef MDU_DIV_EN
      is_div_q <= is_div_d;
      neg_r_q  <= neg_r_d;
      bzero_q  <= bzero_d;
`endif
    end
  end

  assign Busy = (state_q == RUN);
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// tb_mdu: directed self-checking bench for mdu. Divide vectors are used when
// MDU_DIV_EN is defined; otherwise div/divu are checked to be no-ops.
module tb_mdu;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Start;
  logic [2:0]  MDOp;
  logic [31:0] A, B;
  logic        Busy;
  logic [31:0] HI, LO;

  int tests = 0;
  int fails = 0;

  mdu #(.WIDTH(32)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .MDOp(MDOp),
    .A(A), .B(B), .Busy(Busy), .HI(HI), .LO(LO)
  );

  always #5 Clk = ~Clk;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Issue one request, scramble the operands after the accept edge, then count
  // edges until Busy drops (bounded).
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic busy_acc, output int cycles);
    MDOp  = op;
    A     = a;
    B     = b;
    Start = 1'b1;
    tick();
    Start    = 1'b0;
    busy_acc = Busy;
    A        = ~a;
    B        = ~b;
    MDOp     = 3'b110;
    cycles   = 0;
    while (Busy && cycles < 100) begin
      tick();
      cycles++;
    end
  endtask

  task automatic test_reset();
    tests++; if (Busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", Busy); end
    tests++; if (HI !== 32'h0) begin fails++; $display("FAIL reset_hi: got %h expected 00000000", HI); end
    tests++; if (LO !== 32'h0) begin fails++; $display("FAIL reset_lo: got %h expected 00000000", LO); end
  endtask

  // One iterative operation with full-latency and result checks.
  task automatic test_arith(input string name, input logic [2:0] op,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    logic busy_acc;
    int   cycles;
    run_op(op, a, b, busy_acc, cycles);
    tests++; if (busy_acc !== 1'b1) begin fails++; $display("FAIL %s_busy: got %b expected 1", name, busy_acc); end
    tests++; if (cycles != 32) begin fails++; $display("FAIL %s_latency: got %0d expected 32", name, cycles); end
    tests++; if (HI !== exp_hi) begin fails++; $display("FAIL %s_hi: got %h expected %h", name, HI, exp_hi); end
    tests++; if (LO !== exp_lo) begin fails++; $display("FAIL %s_lo: got %h expected %h", name, LO, exp_lo); end
  endtask

  task automatic test_mult();
    test_arith("mult_neg1x2", 3'b000, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    test_arith("mult_negxneg", 3'b000, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 32'h0000_0000, 32'h0000_000F);
    test_arith("mult_minxmin", 3'b000, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
  endtask

  // multu immediately followed by another accept on the very next edge.
  task automatic test_back_to_back();
    test_arith("multu_max2", 3'b001, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE);
    test_arith("b2b_mult", 3'b001, 32'h0000_0003, 32'h0000_0005, 32'h0000_0000, 32'h0000_000F);
  endtask

  task automatic test_mthi_mtlo();
    logic busy_acc;
    int   cycles;
    run_op(3'b100, 32'h1234_5678, 32'h0, busy_acc, cycles);
    tests++; if (HI !== 32'h1234_5678) begin fails++; $display("FAIL mthi_hi: got %h expected 12345678", HI); end
    tests++; if (busy_acc !== 1'b0) begin fails++; $display("FAIL mthi_busy: got %b expected 0", busy_acc); end
    tests++; if (LO !== 32'h0000_000F) begin fails++; $display("FAIL mthi_lo_kept: got %h expected 0000000f", LO); end
    run_op(3'b101, 32'hCAFE_F00D, 32'h0, busy_acc, cycles);
    tests++; if (LO !== 32'hCAFE_F00D) begin fails++; $display("FAIL mtlo_lo: got %h expected cafef00d", LO); end
    tests++; if (HI !== 32'h1234_5678) begin fails++; $display("FAIL mtlo_hi_kept: got %h expected 12345678", HI); end
    tests++; if (busy_acc !== 1'b0) begin fails++; $display("FAIL mtlo_busy: got %b expected 0", busy_acc); end
  endtask

  // A Start while Busy must be ignored and HI/LO must hold until the last edge.
  task automatic test_start_while_busy();
    int cycles;
    MDOp = 3'b001; A = 32'd6; B = 32'd7; Start = 1'b1;
    tick();
    Start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    MDOp = 3'b101; A = 32'h5555_5555; B = 32'h0; Start = 1'b1;
    tick();
    MDOp = 3'b000; A = 32'h0000_0009; B = 32'h0000_0009;
    tick();
    Start = 1'b0;
    tests++; if (LO !== 32'hCAFE_F00D) begin fails++; $display("FAIL busy_lo_held: got %h expected cafef00d", LO); end
    tests++; if (HI !== 32'h1234_5678) begin fails++; $display("FAIL busy_hi_held: got %h expected 12345678", HI); end
    cycles = 7;
    while (Busy && cycles < 100) begin
      tick();
      cycles++;
    end
    tests++; if (cycles != 32) begin fails++; $display("FAIL busy_ignore_latency: got %0d expected 32", cycles); end
    tests++; if (LO !== 32'd42) begin fails++; $display("FAIL busy_ignore_lo: got %h expected 0000002a", LO); end
    tests++; if (HI !== 32'd0) begin fails++; $display("FAIL busy_ignore_hi: got %h expected 00000000", HI); end
  endtask

  // Reset at the 10th RUN edge aborts the operation and clears HI/LO.
  task automatic test_reset_mid_run();
    logic busy_acc;
    int   cycles;
    run_op(3'b100, 32'hAAAA_0001, 32'h0, busy_acc, cycles);
    MDOp = 3'b000; A = 32'h0000_1234; B = 32'h0000_5678; Start = 1'b1;
    tick();
    Start = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    tests++; if (Busy !== 1'b1) begin fails++; $display("FAIL midrun_busy_before: got %b expected 1", Busy); end
    Reset = 1'b0;
    MDOp = 3'b100; A = 32'hFFFF_0000; Start = 1'b1;
    tick();
    Reset = 1'b1;
    Start = 1'b0;
    tests++; if (Busy !== 1'b0) begin fails++; $display("FAIL midrun_reset_busy: got %b expected 0", Busy); end
    tests++; if (HI !== 32'h0) begin fails++; $display("FAIL midrun_reset_hi: got %h expected 00000000", HI); end
    tests++; if (LO !== 32'h0) begin fails++; $display("FAIL midrun_reset_lo: got %h expected 00000000", LO); end
    tick();
    tests++; if (Busy !== 1'b0) begin fails++; $display("FAIL midrun_stays_idle: got %b expected 0", Busy); end
  endtask

`ifdef MDU_DIV_EN
  task automatic test_div();
    test_arith("div_m7_2", 3'b010, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    test_arith("div_7_m2", 3'b010, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
    test_arith("divu_100_7", 3'b011, 32'd100, 32'd7, 32'd2, 32'd14);
    test_arith("divu_by0", 3'b011, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF);
    test_arith("div_by0", 3'b010, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
    test_arith("div_ovf", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
  endtask
`else
  task automatic test_div_disabled();
    logic busy_acc;
    int   cycles;
    run_op(3'b101, 32'h0BAD_CAFE, 32'h0, busy_acc, cycles);
    run_op(3'b011, 32'd7, 32'd2, busy_acc, cycles);
    tests++; if (busy_acc !== 1'b0) begin fails++; $display("FAIL nodiv_busy: got %b expected 0", busy_acc); end
    tick();
    tests++; if (Busy !== 1'b0) begin fails++; $display("FAIL nodiv_busy_later: got %b expected 0", Busy); end
    tests++; if (LO !== 32'h0BAD_CAFE) begin fails++; $display("FAIL nodiv_lo: got %h expected 0badcafe", LO); end
    tests++; if (HI !== 32'h0) begin fails++; $display("FAIL nodiv_hi: got %h expected 00000000", HI); end
    run_op(3'b010, 32'hFFFF_FFF9, 32'd2, busy_acc, cycles);
    tests++; if (busy_acc !== 1'b0) begin fails++; $display("FAIL nodiv_div_busy: got %b expected 0", busy_acc); end
    tests++; if (LO !== 32'h0BAD_CAFE) begin fails++; $display("FAIL nodiv_div_lo: got %h expected 0badcafe", LO); end
  endtask
`endif

  initial begin
    Reset = 1'b0;
    Start = 1'b0;
    MDOp  = 3'b110;
    A     = 32'h0;
    B     = 32'h0;
    tick();
    tick();
    test_reset();
    Reset = 1'b1;
    test_mult();
    test_back_to_back();
    test_mthi_mtlo();
    test_start_while_busy();
    test_reset_mid_run();
`ifdef MDU_DIV_EN
    test_div();
`else
    test_div_disabled();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
